// File: rtl/sensor_pkg.sv
// Shared types and helpers for the sensor readout path.
// Imported by the readout top and its output FIFO.
package sensor_pkg;

   typedef enum logic [1:0] {RO_IDLE, RO_REF, RO_SIG} readout_state_t;

   // Index width that stays at least one bit even for a single-pixel frame.
   function automatic int idx_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/pixel_readout_sync_fifo.sv
// Synchronous FIFO with a first-word-fall-through head and active-low sync reset.
// The head reads as zero while empty so downstream never sees stale RAM contents.
module sync_fifo
   import sensor_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == (PW + 1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign do_push = push_i & (~full_o | do_pop);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/pixel_readout.sv
// Captures ADC samples during the sequencer READ phase, optionally applies
// correlated double sampling, and streams pixels out through a small FIFO.
module pixel_readout
   import sensor_pkg::*;
#(
   parameter int  PIXEL_COUNT = 4,
   parameter int  DATA_W      = 8,
   parameter int  FIFO_DEPTH  = 4,
   localparam int IDX_W       = idx_width(PIXEL_COUNT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              erase,
   input  logic              cds,
   input  logic              read,
   input  logic [IDX_W-1:0]  pixel_select,
   input  logic [DATA_W-1:0] pixel_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              overflow
);

   readout_state_t    state_q;
   logic              erase_q;
   logic              read_q;
   logic              cds_f_q;
   logic              overflow_q;
   logic [DATA_W-1:0] ref_mem [PIXEL_COUNT];

   logic              frame_start;
   logic              read_fall;
   logic              sel_ok;
   logic              ref_we;
   logic              push;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] sig_val;
   logic [DATA_W:0]   head;

   assign frame_start = erase & ~erase_q;
   assign read_fall   = read_q & ~read;
   assign sel_ok      = int'(pixel_select) < PIXEL_COUNT;

   // The restart cycle itself captures nothing: the abandoned phase is over.
   assign ref_we = (state_q == RO_REF) & read & sel_ok & ~frame_start;
   assign push   = (state_q == RO_SIG) & read & sel_ok & ~frame_start;
   assign drop   = push & fifo_full & ~out_ready;

   // One extra bit keeps the sign so a dark signal above the reset level clamps to zero.
   assign diff    = {1'b0, ref_mem[pixel_select]} - {1'b0, pixel_data};
   assign sig_val = !cds_f_q ? pixel_data : (diff[DATA_W] ? '0 : diff[DATA_W-1:0]);

   always_ff @(posedge clk) begin
      if (ref_we) ref_mem[pixel_select] <= pixel_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= RO_IDLE;
         erase_q    <= 1'b0;
         read_q     <= 1'b0;
         cds_f_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         erase_q <= erase;
         read_q  <= read;
         if (frame_start) begin
            cds_f_q    <= cds;
            overflow_q <= 1'b0;
            state_q    <= cds ? RO_REF : RO_SIG;
         end else begin
            if (drop) overflow_q <= 1'b1;
            case (state_q)
               RO_REF:  if (read_fall) state_q <= RO_SIG;
               RO_SIG:  if (read_fall) state_q <= RO_IDLE;
               default: state_q <= RO_IDLE;
            endcase
         end
      end
   end

   sync_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_ni      (reset),
      .push_i      (push),
      .push_data_i ({sig_val, pixel_select == IDX_W'(PIXEL_COUNT - 1)}),
      .pop_i       (out_ready),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign out_data  = head[DATA_W:1];
   assign out_last  = head[0];
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: a queue-based frame model checked every
// cycle, plus literal expectations on the popped pixel stream.
module tb_pixel_readout;

   localparam int PIXEL_COUNT = 4;
   localparam int DATA_W      = 8;
   localparam int FIFO_DEPTH  = 4;
   localparam int PH_IDLE = 0, PH_REF = 1, PH_SIG = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              erase = 1'b0;
   logic              cds = 1'b0;
   logic              read = 1'b0;
   logic [1:0]        pixel_select = '0;
   logic [DATA_W-1:0] pixel_data = '0;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_last;
   logic              overflow;

   pixel_readout #(
      .PIXEL_COUNT (PIXEL_COUNT),
      .DATA_W      (DATA_W),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .erase        (erase),
      .cds          (cds),
      .read         (read),
      .pixel_select (pixel_select),
      .pixel_data   (pixel_data),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural frame model: phase, reference levels, expected FIFO contents.
   typedef struct {
      int v;
      bit last;
   } ent_t;

   ent_t m_q[$];
   int   m_ref [PIXEL_COUNT];
   int   m_phase = PH_IDLE;
   bit   m_cds = 1'b0;
   bit   m_ovf = 1'b0;
   bit   m_erase_prev = 1'b0;
   bit   m_read_prev = 1'b0;

   always @(posedge clk) begin : model
      bit   start, fall, pop, push;
      int   v, r;
      ent_t e;
      push = 1'b0;
      v = 0;
      if (!reset) begin
         m_q.delete();
         m_phase = PH_IDLE;
         m_ovf = 1'b0;
         m_cds = 1'b0;
         m_erase_prev = 1'b0;
         m_read_prev = 1'b0;
      end else begin
         start = erase && !m_erase_prev;
         fall  = m_read_prev && !read;
         pop   = out_ready && (m_q.size() > 0);
         if (start) begin
            m_cds = cds;
            m_ovf = 1'b0;
            m_phase = cds ? PH_REF : PH_SIG;
         end else begin
            if (read && int'(pixel_select) < PIXEL_COUNT) begin
               if (m_phase == PH_REF) begin
                  m_ref[pixel_select] = int'(pixel_data);
               end else if (m_phase == PH_SIG) begin
                  push = 1'b1;
                  r = m_ref[pixel_select];
                  if (m_cds) v = (r > int'(pixel_data)) ? r - int'(pixel_data) : 0;
                  else       v = int'(pixel_data);
               end
            end
            if (fall && m_phase == PH_REF)      m_phase = PH_SIG;
            else if (fall && m_phase == PH_SIG) m_phase = PH_IDLE;
         end
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (m_q.size() < FIFO_DEPTH) begin
               e.v = v;
               e.last = (int'(pixel_select) == PIXEL_COUNT - 1);
               m_q.push_back(e);
            end else begin
               m_ovf = 1'b1;
            end
         end
         m_erase_prev = erase;
         m_read_prev = read;
      end
   end

   int log_v[$];
   bit log_l[$];

   // Per-cycle comparison against the model; also records every accepted pixel.
   always @(negedge clk) begin
      if (chk_en) begin
         check("valid", 32'(out_valid), 32'(m_q.size() > 0));
         check("data", 32'(out_data), (m_q.size() > 0) ? m_q[0].v : 0);
         check("last", 32'(out_last), (m_q.size() > 0) ? 32'(m_q[0].last) : 0);
         check("overflow", 32'(overflow), 32'(m_ovf));
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            log_v.push_back(int'(out_data));
            log_l.push_back(out_last);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic c);
      erase = 1'b1;
      cds = c;
      tick();
      erase = 1'b0;
      tick();
   endtask

   task automatic read_px(input int sel, input int data);
      read = 1'b1;
      pixel_select = 2'(sel);
      pixel_data = 8'(data);
      tick();
   endtask

   task automatic end_read();
      read = 1'b0;
      tick();
   endtask

   task automatic expect_pop(input string nm, input int v, input bit l);
      check({nm, "_present"}, 32'(log_v.size() > 0), 1);
      if (log_v.size() > 0) begin
         check(nm, log_v.pop_front(), v);
         check({nm, "_last"}, 32'(log_l.pop_front()), 32'(l));
      end
   endtask

   initial begin
      reset = 1'b0;
      tick();
      tick();
      chk_en = 1'b1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_ovf", 32'(overflow), 0);
      reset = 1'b1;
      tick();

      // Plain frame, sink always ready.
      out_ready = 1'b1;
      start_frame(1'b0);
      read_px(0, 10); read_px(1, 20); read_px(2, 30); read_px(3, 40);
      end_read();
      repeat (3) tick();
      expect_pop("t2_p0", 10, 1'b0);
      expect_pop("t2_p1", 20, 1'b0);
      expect_pop("t2_p2", 30, 1'b0);
      expect_pop("t2_p3", 40, 1'b1);
      check("t2_extra", log_v.size(), 0);

      // CDS frame with a clamped negative difference.
      start_frame(1'b1);
      read_px(0, 200); read_px(1, 200); read_px(2, 50); read_px(3, 255);
      end_read();
      read_px(0, 50); read_px(1, 210); read_px(2, 50); read_px(3, 0);
      end_read();
      repeat (3) tick();
      expect_pop("t3_p0", 150, 1'b0);
      expect_pop("t3_p1", 0, 1'b0);
      expect_pop("t3_p2", 0, 1'b0);
      expect_pop("t3_p3", 255, 1'b1);
      check("t3_extra", log_v.size(), 0);

      // Stalled sink: fill the FIFO, the fifth sample is dropped.
      out_ready = 1'b0;
      start_frame(1'b0);
      read_px(0, 11); read_px(1, 22); read_px(2, 33); read_px(3, 44);
      read_px(0, 55);
      end_read();
      check("t4_valid", 32'(out_valid), 1);
      check("t4_head", 32'(out_data), 11);
      check("t4_ovf", 32'(overflow), 1);

      // New frame clears overflow; push with simultaneous pop while full.
      start_frame(1'b0);
      check("t5_ovf_clr", 32'(overflow), 0);
      check("t5_head", 32'(out_data), 11);
      out_ready = 1'b1;
      read_px(1, 77);
      out_ready = 1'b0;
      end_read();
      check("t5_ovf", 32'(overflow), 0);
      out_ready = 1'b1;
      repeat (6) tick();
      expect_pop("t5_p0", 11, 1'b0);
      expect_pop("t5_p1", 22, 1'b0);
      expect_pop("t5_p2", 33, 1'b0);
      expect_pop("t5_p3", 44, 1'b1);
      expect_pop("t5_p4", 77, 1'b0);
      check("t5_extra", log_v.size(), 0);

      // Reset mid-stream with data queued and overflow set.
      out_ready = 1'b0;
      start_frame(1'b0);
      read_px(0, 1); read_px(1, 2); read_px(2, 3); read_px(3, 4); read_px(0, 5);
      check("t1_pre_ovf", 32'(overflow), 1);
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      read = 1'b0;
      check("t1_valid", 32'(out_valid), 0);
      check("t1_ovf", 32'(overflow), 0);
      check("t1_data", 32'(out_data), 0);
      tick();
      check("t1_valid_after", 32'(out_valid), 0);

      // Restart during SIG: queued pixels survive, then a CDS frame, then IDLE reads.
      start_frame(1'b0);
      read_px(0, 5); read_px(1, 6);
      erase = 1'b1;
      cds = 1'b1;
      read = 1'b0;
      tick();
      erase = 1'b0;
      tick();
      check("t6_ovf", 32'(overflow), 0);
      check("t6_valid", 32'(out_valid), 1);
      check("t6_head", 32'(out_data), 5);
      read_px(0, 100); read_px(1, 100); read_px(2, 100); read_px(3, 100);
      end_read();
      check("t6_ref_nopush", 32'(out_data), 5);
      out_ready = 1'b1;
      read_px(0, 30); read_px(1, 40); read_px(2, 50); read_px(3, 60);
      end_read();
      tick();
      read_px(0, 123); read_px(1, 124);
      end_read();
      repeat (3) tick();
      expect_pop("t6_p0", 5, 1'b0);
      expect_pop("t6_p1", 6, 1'b0);
      expect_pop("t6_p2", 70, 1'b0);
      expect_pop("t6_p3", 60, 1'b0);
      expect_pop("t6_p4", 50, 1'b0);
      expect_pop("t6_p5", 40, 1'b1);
      check("t6_extra", log_v.size(), 0);
      check("t6_idle_valid", 32'(out_valid), 0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
